// File: rtl/usb2_ep_in_filler_pkg.sv
// Shared constants and state encoding for the USB 2.0 IN endpoint buffer filler.
package usb2_ep_fill_pkg;

  localparam int ADDR_W      = 9;
  localparam int LEN_W       = 11;
  localparam int MAX_PKT_DEF = 512;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    COMMIT  = 2'd2,
    ACK_LOW = 2'd3
  } fill_state_e;

endpackage

// File: rtl/usb2_ep_in_filler_if.sv
// Writer-side endpoint buffer port: byte writes plus a 4-phase commit handshake.
interface usb2_ep_in_filler_if;
  import usb2_ep_fill_pkg::*;

  logic [ADDR_W-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;

  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_in_ready, buf_in_commit_ack
  );

  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_in_ready, buf_in_commit_ack
  );

endinterface

// File: rtl/usb2_ep_in_filler_idle_timer.sv
// Idle down-counter: reloads on clear, counts tick cycles, flags the TIMEOUT-th idle cycle.
module usb2_idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic ext_clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // Reload on clear, otherwise count idle cycles down and hold at zero.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= TW'(TIMEOUT);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  // The cycle that still holds 1 is the TIMEOUT-th consecutive idle cycle.
  assign expired = (TIMEOUT != 0) && tick && (cnt <= TW'(1));

endmodule

// File: rtl/usb2_ep_in_filler.sv
// Packs a valid/ready byte stream into endpoint buffer packets and commits each with its length.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for enable, free buffer and ack low
// FILL    | accepting bytes, one buffer write per accepted byte
// COMMIT  | commit raised with length, waiting for ack high
// ACK_LOW | waiting for ack low; a pending ZLP re-enters COMMIT
module usb2_ep_in_filler
  import usb2_ep_fill_pkg::*;
#(
  parameter int MAX_PKT = MAX_PKT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter bit ZLP_EN  = 1'b1
) (
  input  logic                ext_clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  usb2_ep_in_filler_if.master buf_in,
  output logic [15:0]         stat_pkts,
  output logic                stat_busy
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_FILL    = FILL;
  localparam logic [1:0] S_COMMIT  = COMMIT;
  localparam logic [1:0] S_ACK_LOW = ACK_LOW;

  logic [1:0]        state, state_nxt;
  logic [LEN_W-1:0]  count, count_inc, len_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        data_r;
  logic              wren_r, commit_r, zlp_pend;
  logic              accept, at_max, tmo_exp, tmr_clear, tmr_tick;

  assign accept    = s_valid && s_ready;
  assign count_inc = count + LEN_W'(1);
  assign at_max    = (count_inc == LEN_W'(MAX_PKT));
  assign tmr_clear = accept || (state != S_FILL);
  assign tmr_tick  = (state == S_FILL) && !accept;

  assign buf_in.buf_in_addr       = addr_r;
  assign buf_in.buf_in_data       = data_r;
  assign buf_in.buf_in_wren       = wren_r;
  assign buf_in.buf_in_commit     = commit_r;
  assign buf_in.buf_in_commit_len = len_r;

  usb2_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .ext_clk (ext_clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmo_exp)
  );

  // Next-state decode; a byte accepted together with an enable drop is still written and committed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (enable && buf_in.buf_in_ready && !buf_in.buf_in_commit_ack) state_nxt = S_FILL;
      S_FILL:
        if (accept && (at_max || s_last))          state_nxt = S_COMMIT;
        else if (!enable)                          state_nxt = (accept || count != '0) ? S_COMMIT : S_IDLE;
        else if (tmo_exp && (count != '0))         state_nxt = S_COMMIT;
      S_COMMIT:
        if (commit_r && buf_in.buf_in_commit_ack)  state_nxt = S_ACK_LOW;
      S_ACK_LOW:
        if (!buf_in.buf_in_commit_ack)             state_nxt = zlp_pend ? S_COMMIT : S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // State, byte writes, commit handshake and statistics, all registered.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      s_ready   <= 1'b0;
      stat_busy <= 1'b0;
      stat_pkts <= '0;
      count     <= '0;
      zlp_pend  <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
      wren_r    <= 1'b0;
      commit_r  <= 1'b0;
      len_r     <= '0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == S_FILL);
      stat_busy <= (state_nxt != S_IDLE);
      wren_r    <= accept;
      if (accept) begin
        addr_r <= count[ADDR_W-1:0];
        data_r <= s_data;
        count  <= count_inc;
        if (ZLP_EN && s_last && at_max) zlp_pend <= 1'b1;
      end
      if ((state == S_IDLE) && (state_nxt == S_FILL)) begin
        count    <= '0;
        zlp_pend <= 1'b0;
      end
      if (state == S_COMMIT) begin
        if (!commit_r) begin
          commit_r <= 1'b1;
          len_r    <= count;
        end else if (buf_in.buf_in_commit_ack) begin
          commit_r  <= 1'b0;
          stat_pkts <= stat_pkts + 16'd1;
        end
      end
      if ((state == S_ACK_LOW) && (state_nxt == S_COMMIT)) begin
        count    <= '0;
        zlp_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb2_ep_in_filler.sv
// Directed bench for usb2_ep_in_filler: table of stream transfers plus reset/ready corner sequences.
module tb_usb2_ep_in_filler;
  import usb2_ep_fill_pkg::*;

  localparam int TMO = 16;

  logic        ext_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic [7:0]  s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_ready, nz_s_ready;
  logic [15:0] stat_pkts, nz_stat_pkts;
  logic        stat_busy, nz_stat_busy;

  usb2_ep_in_filler_if bif ();
  usb2_ep_in_filler_if bnz ();

  usb2_ep_in_filler #(.MAX_PKT(512), .TIMEOUT(TMO), .ZLP_EN(1'b1)) dut (
    .ext_clk (ext_clk), .reset_n (reset_n), .enable (enable),
    .s_data (s_data), .s_valid (s_valid), .s_last (s_last), .s_ready (s_ready),
    .buf_in (bif), .stat_pkts (stat_pkts), .stat_busy (stat_busy)
  );

  usb2_ep_in_filler #(.MAX_PKT(512), .TIMEOUT(TMO), .ZLP_EN(1'b0)) dut_nz (
    .ext_clk (ext_clk), .reset_n (reset_n), .enable (enable),
    .s_data (s_data), .s_valid (s_valid), .s_last (s_last), .s_ready (nz_s_ready),
    .buf_in (bnz), .stat_pkts (nz_stat_pkts), .stat_busy (nz_stat_busy)
  );

  initial forever #5 ext_clk = ~ext_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ack_en = 1'b1;

  // monitor state
  int n_com, nz_com, wr_cnt, wr_bad, pkt_addr, last_acc;
  logic [7:0] exp_data;
  int c_len[4];
  int c_cyc[4];
  int c_wr[4];
  logic commit_q, nz_q;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_com = 0; nz_com = 0; wr_cnt = 0; wr_bad = 0; pkt_addr = 0; exp_data = '0;
    last_acc = 0; commit_q = 1'b0; nz_q = 1'b0;
    for (int i = 0; i < 4; i++) begin c_len[i] = -1; c_cyc[i] = 0; c_wr[i] = 0; end
  endtask

  initial forever begin
    @(posedge ext_clk);
    cyc++;
  end

  // buffer-side responders: ack 5 cycles after commit, release once commit drops
  initial begin
    int cnt;
    cnt = 0;
    bif.buf_in_ready = 1'b1;
    bif.buf_in_commit_ack = 1'b0;
    forever begin
      @(posedge ext_clk); #1;
      if (!bif.buf_in_commit_ack) begin
        if (bif.buf_in_commit && ack_en) begin
          cnt++;
          if (cnt == 5) bif.buf_in_commit_ack = 1'b1;
        end else cnt = 0;
      end else if (!bif.buf_in_commit) begin
        bif.buf_in_commit_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    bnz.buf_in_ready = 1'b1;
    bnz.buf_in_commit_ack = 1'b0;
    forever begin
      @(posedge ext_clk); #1;
      if (!bnz.buf_in_commit_ack) begin
        if (bnz.buf_in_commit) begin
          cnt++;
          if (cnt == 5) bnz.buf_in_commit_ack = 1'b1;
        end else cnt = 0;
      end else if (!bnz.buf_in_commit) begin
        bnz.buf_in_commit_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // write/commit monitor: expected addr restarts per packet, data follows the stream counter
  initial begin
    clr_mon();
    forever begin
      @(negedge ext_clk);
      if (bif.buf_in_wren) begin
        if (bif.buf_in_addr != 9'(pkt_addr) || bif.buf_in_data != exp_data) wr_bad++;
        if (bif.buf_in_commit) wr_bad++;
        wr_cnt++; pkt_addr++; exp_data = exp_data + 8'd1;
      end
      if (bif.buf_in_commit && commit_q && n_com > 0 && n_com <= 4)
        if (32'(bif.buf_in_commit_len) != c_len[n_com-1]) wr_bad++;
      if (bif.buf_in_commit && !commit_q) begin
        if (n_com < 4) begin
          c_len[n_com] = 32'(bif.buf_in_commit_len);
          c_cyc[n_com] = cyc;
          c_wr[n_com]  = wr_cnt;
        end
        n_com++;
        pkt_addr = 0;
      end
      commit_q = bif.buf_in_commit;
      if (bnz.buf_in_commit && !nz_q) nz_com++;
      nz_q = bnz.buf_in_commit;
    end
  end

  task automatic do_reset(input bit ready_after);
    reset_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; enable = 1'b1;
    bif.buf_in_ready = ready_after;
    repeat (3) @(posedge ext_clk);
    #1;
    clr_mon();
    reset_n = 1'b1;
    @(posedge ext_clk); #1;
  endtask

  task automatic send(input int n, input bit last);
    int g;
    for (int i = 0; i < n; i++) begin
      s_data = 8'(i); s_valid = 1'b1; s_last = last && (i == n - 1);
      g = 0;
      @(negedge ext_clk);
      while (!s_ready && g < 3000) begin @(negedge ext_clk); g++; end
      if (!s_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout actual byte %0d required %0d bytes", i, n);
        break;
      end
      last_acc = cyc;
      @(posedge ext_clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_commits(input int n);
    int g;
    g = 0;
    while ((n_com < n || bif.buf_in_commit || bif.buf_in_commit_ack) && g < 6000) begin
      @(negedge ext_clk); g++;
    end
    if (g >= 6000) begin
      checks++; errors++;
      $display("FAIL wait_commits actual %0d required %0d", n_com, n);
    end
    repeat (40) @(negedge ext_clk);
  endtask

  typedef struct {
    int nbytes; bit last; int exp_n; int len0; int len1; int nz_n; int lat_idx; int lat;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{1024, 1'b0, 2, 512, 512, 2, 0, 0};
    tv[1] = '{100,  1'b1, 1, 100, 0,   1, 0, 2};
    tv[2] = '{512,  1'b1, 2, 512, 0,   1, 0, 2};
    tv[3] = '{10,   1'b0, 1, 10,  0,   1, 0, TMO + 2};
    tv[4] = '{8,    1'b1, 1, 8,   0,   1, 0, 2};
    tv[5] = '{513,  1'b1, 2, 512, 1,   2, 1, 2};

    // reset values
    #2;
    chk("reset_outputs", longint'({s_ready, bif.buf_in_addr, bif.buf_in_data, bif.buf_in_wren,
        bif.buf_in_commit, bif.buf_in_commit_len, stat_pkts, stat_busy}), 0);

    for (int t = 0; t < 6; t++) begin
      do_reset(1'b1);
      send(tv[t].nbytes, tv[t].last);
      if (tv[t].last) chk($sformatf("t%0d_sready_after_last", t), longint'(s_ready), 0);
      wait_commits(tv[t].exp_n);
      chk($sformatf("t%0d_commits", t), n_com, tv[t].exp_n);
      chk($sformatf("t%0d_len0", t), c_len[0], tv[t].len0);
      chk($sformatf("t%0d_wr_at_commit0", t), c_wr[0], tv[t].len0);
      if (tv[t].exp_n > 1) begin
        chk($sformatf("t%0d_len1", t), c_len[1], tv[t].len1);
        chk($sformatf("t%0d_wr_at_commit1", t), c_wr[1], tv[t].nbytes);
      end
      chk($sformatf("t%0d_stat_pkts", t), longint'(stat_pkts), tv[t].exp_n);
      chk($sformatf("t%0d_nozlp_commits", t), nz_com, tv[t].nz_n);
      chk($sformatf("t%0d_writes", t), wr_cnt, tv[t].nbytes);
      chk($sformatf("t%0d_write_protocol_errs", t), wr_bad, 0);
      if (tv[t].lat != 0)
        chk($sformatf("t%0d_commit_latency", t), c_cyc[tv[t].lat_idx] - last_acc, tv[t].lat);
    end

    // buffer not ready: stay idle, then FILL the cycle after ready rises
    do_reset(1'b0);
    s_data = 8'h00; s_valid = 1'b1;
    repeat (10) @(negedge ext_clk);
    chk("notready_sready", longint'(s_ready), 0);
    chk("notready_busy", longint'(stat_busy), 0);
    chk("notready_writes", wr_cnt, 0);
    @(posedge ext_clk); #1;
    bif.buf_in_ready = 1'b1;
    @(posedge ext_clk); #1;
    chk("ready_rise_sready", longint'(s_ready), 1);
    chk("ready_rise_busy", longint'(stat_busy), 1);
    s_valid = 1'b0;

    // reset mid-packet: outputs clear at once, no commit, next packet starts at addr 0
    do_reset(1'b1);
    send(300, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_outputs", longint'({s_ready, bif.buf_in_addr, bif.buf_in_data, bif.buf_in_wren,
        bif.buf_in_commit, bif.buf_in_commit_len, stat_pkts, stat_busy}), 0);
    chk("midreset_no_commit", n_com, 0);
    do_reset(1'b1);
    send(512, 1'b0);
    wait_commits(1);
    chk("after_reset_len", c_len[0], 512);
    chk("after_reset_writes", wr_cnt, 512);
    chk("after_reset_protocol_errs", wr_bad, 0);

    // reset while commit is held high drops it asynchronously
    do_reset(1'b1);
    ack_en = 1'b0;
    send(8, 1'b1);
    repeat (6) @(negedge ext_clk);
    chk("hold_commit_high", longint'(bif.buf_in_commit), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_drops_commit", longint'(bif.buf_in_commit), 0);
    ack_en = 1'b1;
    do_reset(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual %0d required %0d", cyc, 0);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/usb2_ep_in_filler.md
# usb2_ep_in_filler

Writer-side client for a USB 2.0 device IN endpoint buffer. Accepts a byte stream with valid/ready handshake, packs it into packets of up to MAX_PKT bytes in the endpoint's dual-port buffer, and commits each packet with its length. Sits on the external-clock side of the protocol layer's endpoint buffer interface (buf_in_* group), e.g. feeding EP3 transport-stream data or the EP1 bulk IN path.

## Interface
- MAX_PKT, 512: maximum packet payload in bytes; power of two, 8..512.
- TIMEOUT, 1024: idle cycles before a partial packet is flushed; 0 disables the flush.
- ZLP_EN, 1: send a zero-length packet when s_last ends a packet of exactly MAX_PKT bytes.
- ext_clk  in  1  buffer-side clock; sole clock of the block.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  allow new packets to start.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  byte ends a transfer; packet committed short.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- buf_in_addr  out  9  buffer write address.
- buf_in_data  out  8  buffer write data.
- buf_in_wren  out  1  buffer write strobe.
- buf_in_ready  in  1  buffer free for filling.
- buf_in_commit  out  1  commit request, level, 4-phase.
- buf_in_commit_len  out  11  committed byte count, 0..MAX_PKT.
- buf_in_commit_ack  in  1  commit acknowledge.
- stat_pkts  out  16  committed packet count, wraps.
- stat_busy  out  1  state != IDLE.

## Operation
- All outputs registered. Reset values: s_ready 0, buf_in_addr 0, buf_in_data 0, buf_in_wren 0, buf_in_commit 0, buf_in_commit_len 0, stat_pkts 0, stat_busy 0.
- States: IDLE, FILL, COMMIT, ACK_LOW.
- IDLE -> FILL when enable && buf_in_ready && !buf_in_commit_ack; byte count cleared.
- FILL: s_ready = 1. Each accepted byte is written at address = count, then count increments.
- FILL -> COMMIT when: the accepted byte makes count == MAX_PKT; or the accepted byte has s_last; or TIMEOUT != 0, count > 0 and TIMEOUT consecutive cycles pass with no accept; or enable drops while count > 0.
- FILL -> IDLE when enable drops with count == 0; no commit.
- The idle counter resets on every accept and saturates at TIMEOUT.
- COMMIT: buf_in_commit = 1, buf_in_commit_len = count. Hold until buf_in_commit_ack = 1, then drop commit, increment stat_pkts, go to ACK_LOW.
- ACK_LOW: wait for buf_in_commit_ack = 0.
  - If zlp_pend, go to COMMIT with count = 0 and clear zlp_pend.
  - Otherwise go to IDLE.
- zlp_pend is set when ZLP_EN and s_last is accepted on the byte that makes count == MAX_PKT.
- Count width is 11 bits. Address = count[8:0]; it never wraps within a packet.
- Simultaneous s_last and count reaching MAX_PKT: one full commit, then a ZLP if ZLP_EN, else nothing more.
- Reset mid-packet discards the partial packet, with no commit. Reset during COMMIT drops buf_in_commit asynchronously.

## Timing
- Byte accepted in cycle N: buf_in_wren, addr and data are valid in cycle N+1, as a single-cycle pulse. Back-to-back accepts give back-to-back writes.
- Final byte accepted in cycle N: s_ready is 0 from N+1, and buf_in_commit rises in N+2, strictly after the last wren pulse.
- buf_in_commit_len is stable for the whole time buf_in_commit is high.
- Ack seen high in cycle M: commit is 0 in M+1.
- Minimum inter-packet gap: ACK_LOW plus one IDLE cycle.
- Timeout flush: with the last accept in cycle N, commit rises in N+TIMEOUT+2.

## Structure
- Package usb2_ep_fill_pkg: state enum (IDLE, FILL, COMMIT, ACK_LOW), buffer address width 9, commit length width 11, default MAX_PKT/TIMEOUT constants.
- No sub-module is required. Optionally, the idle-timeout counter is split out as usb2_idle_timer (clear, tick, expired).

## Test plan
- Stream 1024 bytes 0..255 repeating, no s_last, ack after 5 cycles -> two commits of len 512; writes at addr 0..511 with matching data; stat_pkts = 2.
- 100 bytes with s_last on byte 100 -> one commit, len 100; commit rises 2 cycles after the accept of the last byte.
- 512 bytes with s_last on byte 512, ZLP_EN = 1 -> commits of len 512 then len 0, no wren between them; with ZLP_EN = 0 -> single commit.
- 10 bytes then s_valid low, TIMEOUT = 16 -> commit len 10 at last accept + 18 cycles; s_ready stays 0 until ack falls and buf_in_ready is high.
- buf_in_ready low at start -> s_ready 0, no wren; ready rises -> FILL entered the next cycle.
- Assert reset_n low after 300 bytes -> all outputs zero immediately, no commit; after release, a new 512-byte packet starts at addr 0.
